rr_arbiter8: RTL and testbench

- Round-robin arbiter sharing one 8-way resource between 8 requesters.
- Owner index drives a 3-to-8 decoder/demux select, so the grant is produced as both a 3-bit index and a one-hot vector.
- Registered grant with back-to-back handover and an optional hold-time limit.
- Sits between requesting units and the shared demultiplexed datapath.

---
 rtl/rr_arbiter8.sv | 144 ++++++++++++++
 tb/tb_rr_arbiter8.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for eight requesters sharing one
// demultiplexed resource. The grant is registered and presented both as a
// one-hot vector and as a 3-bit decoder select.
//
// Optional feature: define ARB_TIMEOUT_EN to force rotation away from an
// owner that has held the grant for MAX_HOLD cycles while others wait.
// Without it, an owner keeps the grant for as long as it requests, and
// timeout stays 0.
//
// Handshake: req[k] is a level request. Requester k owns the resource from
// the cycle gnt[k] rises. It keeps it for every cycle in which req[k] is
// still high at the clock edge. Dropping req[k] releases the resource at the
// next edge. en only gates new grants and never revokes an existing one.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

`ifdef ARB_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  logic [7:0]       cand;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       scan;
  logic             do_grant;

  // Pick the first candidate at or after ptr, wrapping. The current owner
  // is masked out, so a forced rotation never re-elects the owner.
  always_comb begin
    cand      = req;
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan      = ptr_q;
    if (state_q == GRANT) cand[idx_q] = 1'b0;
    // Scan from the far end backwards so the nearest candidate wins last.
    for (int i = 7; i >= 0; i--) begin
      scan = ptr_q + 3'(i);
      if (cand[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
  end

  // Next-state and next-output decision for the IDLE/GRANT controller.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    to_d     = 1'b0;
    do_grant = 1'b0;
    case (state_q)
      IDLE: begin
        do_grant = en && win_found;
      end
      GRANT: begin
        if (req[idx_q]) begin
          if (TIMEOUT_EN && en && win_found && (cnt_q >= HOLD_LAST)) begin
            do_grant = 1'b1;
            to_d     = 1'b1;
          end else if (cnt_q != HOLD_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (en && win_found) begin
          // Back-to-back handover: no idle cycle between owners.
          do_grant = 1'b1;
        end else begin
          state_d = IDLE;
          idx_d   = 3'd0;
          gnt_d   = 8'd0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        gnt_d   = 8'd0;
        cnt_d   = '0;
      end
    endcase
    if (do_grant) begin
      state_d = GRANT;
      idx_d   = win_idx;
      gnt_d   = 8'b1 << win_idx;
      ptr_d   = win_idx + 3'd1;
      cnt_d   = '0;
    end
  end

  // Controller state and all outputs are held in these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gnt_q   <= 8'd0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4). It follows ARB_TIMEOUT_EN in the same
// way as the design, so one file covers both builds.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: owner (-1 when idle), rotation pointer, and the number
  // of cycles the owner has held the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 0;
  endtask

  // First requester in rotation order starting at p, skipping excl.
  function automatic int pick(input logic [7:0] r, input int p, input int excl);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (p + k) % 8;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [12:0] model_out();
    logic [7:0] g;
    logic [2:0] ix;
    g  = 8'd0;
    ix = 3'd0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      ix = 3'(m_owner);
    end
    return {(m_owner >= 0), ix, g, m_to};
  endfunction

  function automatic logic [12:0] dut_out();
    return {gnt_valid, gnt_idx, gnt, timeout};
  endfunction

  // ---------------- driver ----------------
  // Advance the model on the current inputs, clock the DUT, then settle.
  task automatic tick();
    int w;
    m_to = 0;
    if (m_owner < 0) begin
      w = pick(req, m_ptr, -1);
      if (en && w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % 8; m_held = 1;
      end
    end else if (req[m_owner]) begin
      w = pick(req, m_ptr, m_owner);
      if (TO_EN && en && w >= 0 && m_held >= MAX_HOLD) begin
        m_owner = w; m_ptr = (w + 1) % 8; m_held = 1; m_to = 1;
      end else begin
        m_held++;
      end
    end else begin
      w = pick(req, m_ptr, -1);
      if (en && w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % 8; m_held = 1;
      end else begin
        m_owner = -1; m_held = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] exp_v;
    do_reset();
    exp_v = 13'd0;
    n_cmp++;
    if (dut_out() !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", dut_out(), exp_v);
    end
    en  = 1'b1;
    req = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL idle_no_req cyc%0d: got %h want %h", i, dut_out(), exp_v);
      end
    end
    // Take a grant, then pull reset in the middle of the cycle.
    req = 8'h10;
    tick();
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL pre_reset_grant: got %h want %h", dut_out(), model_out());
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_out() !== exp_v) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", dut_out(), exp_v);
    end
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    en  = 1'b1;
    req = 8'b0000_0100;
    tick();
    n_cmp++;
    if (dut_out() !== {1'b1, 3'd2, 8'h04, 1'b0}) begin
      n_err++;
      $display("FAIL single_grant: got %h want %h", dut_out(), {1'b1, 3'd2, 8'h04, 1'b0});
    end
    tick();
    tick();
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL single_hold: got %h want %h", dut_out(), model_out());
    end
    req = 8'h00;
    tick();
    n_cmp++;
    if (dut_out() !== 13'd0) begin
      n_err++;
      $display("FAIL single_release: got %h want %h", dut_out(), 13'd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_idx;
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    tick();
    n_cmp++;
    if (gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got idx %0d valid %b want idx 0 valid 1", gnt_idx, gnt_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();                                   // second cycle of ownership
      req = 8'hFF & ~(8'b1 << gnt_idx);         // owner releases for one cycle
      tick();
      req = 8'hFF;
      exp_idx = 3'(k % 8);
      n_cmp++;
      if (gnt_idx !== exp_idx || gnt !== (8'b1 << exp_idx) || gnt_valid !== 1'b1 ||
          dut_out() !== model_out()) begin
        n_err++;
        $display("FAIL b2b_handover%0d: got %h want %h", k, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_en_block();
    do_reset();
    en  = 1'b1;
    req = 8'h20;
    tick();
    en  = 1'b0;
    req = 8'h22;
    tick();
    tick();
    n_cmp++;
    if (dut_out() !== {1'b1, 3'd5, 8'h20, 1'b0}) begin
      n_err++;
      $display("FAIL en_low_keeps: got %h want %h", dut_out(), {1'b1, 3'd5, 8'h20, 1'b0});
    end
    req = 8'h02;
    tick();
    n_cmp++;
    if (dut_out() !== 13'd0) begin
      n_err++;
      $display("FAIL en_low_idle: got %h want %h", dut_out(), 13'd0);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if (dut_out() !== {1'b1, 3'd1, 8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL en_high_grant: got %h want %h", dut_out(), {1'b1, 3'd1, 8'h02, 1'b0});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en  = 1'b1;
    req = 8'h08;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 8'h08 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL lone_hold cyc%0d: got gnt %h to %b want gnt 08 to 0", i, gnt, timeout);
      end
    end
    req = 8'h48;
    tick();
    n_cmp++;
    if (dut_out() !== model_out() || timeout !== TO_EN) begin
      n_err++;
      $display("FAIL timeout_edge: got %h want %h", dut_out(), model_out());
    end
    tick();
    n_cmp++;
    if (dut_out() !== model_out() || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_pulse_end: got %h want %h", dut_out(), model_out());
    end
    // The pointer now sits past the new owner: releasing with bits 7 and 3
    // pending must pick 7 after a forced rotation to 6.
    req = TO_EN ? 8'h88 : 8'h48;
    tick();
    tick();
    n_cmp++;
    if (dut_out() !== model_out()) begin
      n_err++;
      $display("FAIL timeout_ptr: got %h want %h", dut_out(), model_out());
    end
  endtask

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    do_reset();
    en  = 1'b1;
    req = 8'h00;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      en = ($urandom_range(0, 7) != 0);
      tick();
      n_cmp++;
      if (dut_out() !== model_out()) begin
        n_err++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random cyc%0d req %h: got %h want %h", i, req, dut_out(), model_out());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_en_block();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
